// File: rtl/ec_fpn_addsub_resp_pkg.sv
// Shared types for the chunked mod-P add/sub responder.
// Contents: FSM state encoding and a small width helper.
package ec_fpn_addsub_resp_pkg;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    OUT
  } state_t;

  // Counter width for n items, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ec_fpn_addsub_resp_if.sv
// Streaming handshake bundle used between point-arithmetic requesters and
// their add/sub responders.
// Signals: val/rdy handshake, dat payload (DAT_BITS), sop/eop packet framing,
// ctl tag (CTL_BITS) and err.
// Modports: source drives payload and reads rdy; sink reads payload, drives rdy.
interface if_axi_stream #(
  parameter int DAT_BITS = 64,
  parameter int CTL_BITS = 8
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport source (output val, sop, eop, err, dat, ctl, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, output rdy);
endinterface

// File: rtl/ec_fpn_chunk_addsub.sv
// Combinational A-bit add/subtract cell with carry/borrow.
// Ports: x, y (A bits) operands; cin carry-in (add) or borrow-in (sub);
// mode 0 = x + y + cin, 1 = x - y - cin; z result; cout carry/borrow out.
module ec_fpn_chunk_addsub #(
  parameter int A = 64
) (
  input  logic [A-1:0] x,
  input  logic [A-1:0] y,
  input  logic         cin,
  input  logic         mode,
  output logic [A-1:0] z,
  output logic         cout
);
  logic [A:0] sum;

  // A+1 bit arithmetic: bit A is the carry for add, and the borrow for sub
  // because the difference never drops below -2^A.
  always_comb begin
    if (mode) sum = {1'b0, x} - {1'b0, y} - (A+1)'(cin);
    else      sum = {1'b0, x} + {1'b0, y} + (A+1)'(cin);
    z    = sum[A-1:0];
    cout = sum[A];
  end
endmodule

// File: rtl/ec_fpn_addsub_resp.sv
// Responder for chunked mod-P add (SUB=0) or subtract (SUB=1).
// Ports: i_clk; i_rst async active-high; i_req_if sink carrying {b,a} chunk
// beats LS first with sop/eop/ctl; o_res_if source returning result chunks LS
// first with sop/eop, echoed ctl and err for malformed request packets.
module ec_fpn_addsub_resp
  import ec_fpn_addsub_resp_pkg::*;
#(
  parameter type    FE_TYPE       = logic [255:0],
  parameter type    FE_TYPE_ARITH = logic [63:0],
  parameter FE_TYPE P             = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter int     SUB           = 0,
  parameter int     CTL_BITS      = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.sink    i_req_if,
  if_axi_stream.source  o_res_if
);
  localparam int W        = $bits(FE_TYPE);
  localparam int A        = $bits(FE_TYPE_ARITH);
  localparam int DIV      = W / A;
  localparam int DIV_LOG2 = cnt_bits(DIV);
  localparam logic [DIV_LOG2-1:0] LAST   = DIV_LOG2'(DIV - 1);
  localparam logic [W-1:0]        P_BITS = P;
  localparam logic                OP_SUB = (SUB != 0);

  state_t state, state_nxt;

  logic [A-1:0]          a_q [DIV];
  logic [A-1:0]          b_q [DIV];
  logic [A-1:0]          r1_q[DIV];   // primary op result: s (add) or d (sub)
  logic [A-1:0]          r2_q[DIV];   // P-corrected result: t (add) or u (sub)
  logic [DIV_LOG2-1:0]   k_q, cnt_q;
  logic                  full_q, fault_q, c1_q, c2_q;
  logic [CTL_BITS-1:0]   ctl_q;

  logic                  out_val_q, out_sop_q, out_eop_q, out_err_q;
  logic [A-1:0]          out_dat_q;
  logic [CTL_BITS-1:0]   out_ctl_q;

  logic [A-1:0]          p_chunk, z1, z2, res_chunk;
  logic                  cout1, cout2, sel_corr, first_beat, beat_in;

  ec_fpn_chunk_addsub #(.A(A)) u_op (
    .x(a_q[cnt_q]), .y(b_q[cnt_q]), .cin(c1_q), .mode(OP_SUB), .z(z1), .cout(cout1)
  );

  ec_fpn_chunk_addsub #(.A(A)) u_fix (
    .x(z1), .y(p_chunk), .cin(c2_q), .mode(~OP_SUB), .z(z2), .cout(cout2)
  );

  always_comb begin
    p_chunk    = P_BITS[int'(cnt_q)*A +: A];
    // Add keeps s - P when the sum overflowed W bits or did not borrow
    // against P; sub adds P back only when a - b borrowed.
    sel_corr   = OP_SUB ? c1_q : (c1_q || !c2_q);
    res_chunk  = sel_corr ? r2_q[cnt_q] : r1_q[cnt_q];
    first_beat = !full_q && (k_q == '0);
    beat_in    = (state == LOAD) && i_req_if.val;
  end

  assign i_req_if.rdy = (state == LOAD) && !i_rst;

  assign o_res_if.val = out_val_q;
  assign o_res_if.sop = out_sop_q;
  assign o_res_if.eop = out_eop_q;
  assign o_res_if.err = out_err_q;
  assign o_res_if.dat = out_dat_q;
  assign o_res_if.ctl = out_ctl_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (i_req_if.val && i_req_if.eop) state_nxt = CALC;
      CALC:    if (cnt_q == LAST) state_nxt = OUT;
      OUT:     if (out_val_q && out_eop_q && o_res_if.rdy) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DIV; i++) begin
        a_q[i]  <= '0;
        b_q[i]  <= '0;
        r1_q[i] <= '0;
        r2_q[i] <= '0;
      end
      k_q       <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      fault_q   <= 1'b0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      ctl_q     <= '0;
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_err_q <= 1'b0;
      out_dat_q <= '0;
      out_ctl_q <= '0;
    end else begin
      case (state)
        LOAD: if (beat_in) begin
          if (!full_q) begin
            a_q[k_q] <= i_req_if.dat[A-1:0];
            b_q[k_q] <= i_req_if.dat[2*A-1:A];
          end
          if (first_beat) ctl_q <= i_req_if.ctl;
          fault_q <= fault_q | (first_beat & ~i_req_if.sop) | full_q
                   | (i_req_if.eop & ~full_q & (k_q != LAST));
          // full_q parks the counter once DIV chunks are in, so surplus
          // beats are swallowed instead of wrapping onto chunk 0.
          if (i_req_if.eop) begin
            k_q    <= '0;
            full_q <= 1'b0;
            cnt_q  <= '0;
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
          end else if (!full_q) begin
            if (k_q == LAST) full_q <= 1'b1;
            else             k_q    <= k_q + 1'b1;
          end
        end
        CALC: begin
          r1_q[cnt_q] <= z1;
          r2_q[cnt_q] <= z2;
          c1_q        <= cout1;
          c2_q        <= cout2;
          cnt_q       <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        OUT: if (!out_val_q || o_res_if.rdy) begin
          if (out_val_q && out_eop_q) begin
            out_val_q <= 1'b0;
            out_sop_q <= 1'b0;
            out_eop_q <= 1'b0;
            out_err_q <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
            // Short packets rely on unsent chunks reading as zero.
            for (int unsigned i = 0; i < DIV; i++) begin
              a_q[i] <= '0;
              b_q[i] <= '0;
            end
          end else begin
            out_val_q <= 1'b1;
            out_dat_q <= res_chunk;
            out_sop_q <= (cnt_q == '0);
            out_eop_q <= (cnt_q == LAST);
            out_ctl_q <= ctl_q;
            out_err_q <= fault_q;
            if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ec_fpn_addsub_resp.sv
// Bench for ec_fpn_addsub_resp: an add and a sub instance share identical
// request streams; results are checked against wide-integer mod-P models.
module tb_ec_fpn_addsub_resp;
  localparam int A   = 64;
  localparam int W   = 256;
  localparam int DIV = W / A;
  localparam int CW  = 8;
  localparam logic [W-1:0] P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef logic [W-1:0] fe_t;
  typedef logic [A-1:0] ch_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  if_axi_stream #(.DAT_BITS(2*A), .CTL_BITS(CW)) req_add ();
  if_axi_stream #(.DAT_BITS(2*A), .CTL_BITS(CW)) req_sub ();
  if_axi_stream #(.DAT_BITS(A),   .CTL_BITS(CW)) res_add ();
  if_axi_stream #(.DAT_BITS(A),   .CTL_BITS(CW)) res_sub ();

  ec_fpn_addsub_resp #(
    .FE_TYPE(fe_t), .FE_TYPE_ARITH(ch_t), .P(P), .SUB(0), .CTL_BITS(CW)
  ) u_add (
    .i_clk(clk), .i_rst(rst), .i_req_if(req_add), .o_res_if(res_add)
  );

  ec_fpn_addsub_resp #(
    .FE_TYPE(fe_t), .FE_TYPE_ARITH(ch_t), .P(P), .SUB(1), .CTL_BITS(CW)
  ) u_sub (
    .i_clk(clk), .i_rst(rst), .i_req_if(req_sub), .o_res_if(res_sub)
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: if a+b reaches P, subtract P once; result taken mod 2^W.
  function automatic fe_t model_add(input fe_t a, input fe_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  // Reference: a-b, plus P when a<b; result taken mod 2^W.
  function automatic fe_t model_sub(input fe_t a, input fe_t b);
    fe_t d;
    d = a - b;
    if (a < b) d = d + P;
    return d;
  endfunction

  function automatic fe_t rand_fe();
    fe_t v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_req(input logic v, input logic [2*A-1:0] d, input logic s,
                           input logic e, input logic [CW-1:0] c);
    req_add.val = v; req_add.dat = d; req_add.sop = s; req_add.eop = e; req_add.ctl = c;
    req_sub.val = v; req_sub.dat = d; req_sub.sop = s; req_sub.eop = e; req_sub.ctl = c;
    req_add.err = 1'b0; req_sub.err = 1'b0;
  endtask

  task automatic set_res_rdy(input logic r);
    res_add.rdy = r;
    res_sub.rdy = r;
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic run_txn(input string name, input fe_t a, input fe_t b, input logic [CW-1:0] ctl,
                         input int nbeats, input bit no_sop, input bit bp, input bit abort,
                         input bit exp_err);
    fe_t ea, eb, exp_a, exp_s;
    int  n, j, c;
    bit  r;
    ch_t ca, cb;
    ea = a;
    eb = b;
    for (int k = nbeats; k < DIV; k++) begin
      ea[k*A +: A] = '0;
      eb[k*A +: A] = '0;
    end
    exp_a = model_add(ea, eb);
    exp_s = model_sub(ea, eb);

    for (int k = 0; k < nbeats; k++) begin
      if (k < DIV) begin
        ca = a[k*A +: A];
        cb = b[k*A +: A];
      end else begin
        ca = {$urandom, $urandom};
        cb = {$urandom, $urandom};
      end
      drive_req(1'b1, {cb, ca}, (k == 0) && !no_sop, k == nbeats - 1, ctl);
      n = 0;
      @(negedge clk);
      while (!req_add.rdy && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check_val({name, ".req_timeout"}, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    drive_req(1'b0, '0, 1'b0, 1'b0, '0);

    if (abort) begin
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_val({name, ".rst_val"}, res_add.val, 1'b0);
      check_val({name, ".rst_dat"}, res_add.dat, '0);
      check_val({name, ".rst_ctl"}, res_sub.ctl, '0);
      check_val({name, ".rst_flags"}, {res_add.sop, res_add.eop, res_add.err, res_sub.val}, 4'b0);
      check_val({name, ".rst_rdy"}, req_add.rdy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_val({name, ".rdy_release"}, req_add.rdy, 1'b1);
      @(posedge clk);
      #1;
      return;
    end

    n = 0;
    while (!res_add.val && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({name, ".latency"}, n, DIV + 1);
    check_val({name, ".rdy_busy"}, req_add.rdy, 1'b0);

    j = 0;
    c = 0;
    while (j < DIV && c < 64) begin
      r = bp ? (c % 2 == 0) : 1'b1;
      set_res_rdy(r);
      @(negedge clk);
      check_val($sformatf("%s.val%0d", name, j), {res_add.val, res_sub.val}, 2'b11);
      check_val($sformatf("%s.add%0d", name, j), res_add.dat, exp_a[j*A +: A]);
      check_val($sformatf("%s.sub%0d", name, j), res_sub.dat, exp_s[j*A +: A]);
      check_val($sformatf("%s.sop%0d", name, j), {res_add.sop, res_sub.sop}, {2{j == 0}});
      check_val($sformatf("%s.eop%0d", name, j), {res_add.eop, res_sub.eop}, {2{j == DIV - 1}});
      check_val($sformatf("%s.ctl%0d", name, j), {res_add.ctl, res_sub.ctl}, {ctl, ctl});
      check_val($sformatf("%s.err%0d", name, j), {res_add.err, res_sub.err}, {2{exp_err}});
      check_val($sformatf("%s.rdy%0d", name, j), {req_add.rdy, req_sub.rdy}, 2'b00);
      if (r && res_add.val) j++;
      @(posedge clk);
      #1;
      c++;
    end
    if (j < DIV) check_val({name, ".out_timeout"}, j, DIV);
    set_res_rdy(1'b0);
    check_val({name, ".rdy_rise"}, {req_add.rdy, req_sub.rdy}, 2'b11);
    check_val({name, ".val_drop"}, {res_add.val, res_sub.val}, 2'b00);
  endtask

  initial begin
    fe_t ra, rb;
    drive_req(1'b0, '0, 1'b0, 1'b0, '0);
    set_res_rdy(1'b0);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset.rdy", {req_add.rdy, req_sub.rdy}, 2'b00);
    check_val("reset.val", {res_add.val, res_sub.val}, 2'b00);
    check_val("reset.flags", {res_add.sop, res_add.eop, res_add.err}, 3'b0);
    check_val("reset.dat", res_add.dat, '0);
    check_val("reset.ctl", res_sub.ctl, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("reset.rdy_up", {req_add.rdy, req_sub.rdy}, 2'b11);

    run_txn("a5b7",   256'd5, 256'd7, 8'h10, DIV, 0, 0, 0, 0);
    run_txn("pm1p2",  P - 1,  256'd2, 8'h21, DIV, 0, 0, 0, 0);
    run_txn("carry",  256'hffffffffffffffff, 256'd1, 8'h32, DIV, 0, 0, 0, 0);
    run_txn("a3b5",   256'd3, 256'd5, 8'h43, DIV, 0, 0, 0, 0);
    run_txn("a7b7",   256'd7, 256'd7, 8'h54, DIV, 0, 0, 0, 0);
    run_txn("bp",     rand_fe() % P, rand_fe() % P, 8'h65, DIV, 0, 1, 0, 0);
    run_txn("short",  rand_fe() % P, rand_fe() % P, 8'h76, 3, 0, 0, 0, 1);
    run_txn("clean",  rand_fe() % P, rand_fe() % P, 8'h87, DIV, 0, 0, 0, 0);
    run_txn("nosop",  rand_fe() % P, rand_fe() % P, 8'h98, DIV, 1, 0, 0, 1);
    run_txn("extra",  rand_fe() % P, rand_fe() % P, 8'ha9, DIV + 2, 0, 1, 0, 1);

    for (int i = 0; i < 6; i++) begin
      ra = rand_fe() % P;
      rb = rand_fe() % P;
      run_txn($sformatf("rnd%0d", i), ra, rb, CW'($urandom), DIV, 0, bit'($urandom % 2), 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      run_txn($sformatf("oor%0d", i), rand_fe(), rand_fe(), CW'($urandom), DIV, 0, 0, 0, 0);
    end

    run_txn("abort",  rand_fe(), rand_fe(), 8'hcc, DIV, 0, 0, 1, 0);
    run_txn("post_short", rand_fe() % P, rand_fe() % P, 8'h3d, 3, 0, 0, 0, 1);
    run_txn("post_clean", rand_fe() % P, rand_fe() % P, 8'h4e, DIV, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
